// File: rtl/dac_interp_if.sv
`default_nettype none
// dac_interp_if: sample-stream handshake into dac_interp (rev 1.0).
interface dac_interp_if;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface
`default_nettype wire

// File: rtl/dac_interp.sv
`default_nettype none
// dac_interp: upsamples a signed stream to offset-binary ticks for first_order_dac (rev 1.0).
// Macro DAC_INTERP_LINEAR_EN selects linear interpolation; otherwise zero-order hold.
module dac_interp #(
  parameter int unsigned CLK_DIV    = 10,
  parameter int unsigned RATIO_LOG2 = 4
) (
  input  wire          i_clk,
  input  wire          i_res,
  dac_interp_if.slave  s_bus,
  output logic [15:0]  o_func,
  output logic         o_ce,
  output logic         o_underrun
);

  localparam int unsigned c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_DIV_W-1:0]    c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
  localparam logic [RATIO_LOG2-1:0] c_K_LAST   = '1;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [c_DIV_W-1:0]      div_q, div_d;
  logic [RATIO_LOG2-1:0]   k_q, k_d;
  logic [15:0]             prev_q, prev_d;
  logic [15:0]             cur_q, cur_d;
  logic [15:0]             sbuf_q, sbuf_d;
  logic                    sbuf_full_q, sbuf_full_d;
  logic [15:0]             func_q, func_d;
  logic                    ce_q, ce_d;
  logic                    underrun_q, underrun_d;

  logic                    w_tick;
  logic                    w_xfer;
  logic [15:0]             w_y;

  assign w_tick = (div_q == c_DIV_LAST);
  assign w_xfer = s_bus.s_valid & ~sbuf_full_q;

`ifdef DAC_INTERP_LINEAR_EN
  localparam int unsigned c_PW = 17 + RATIO_LOG2;

  logic signed [16:0]     w_diff;
  logic signed [c_PW-1:0] w_base;
  logic signed [c_PW-1:0] w_prod;
  logic signed [c_PW-1:0] w_sum;
  logic [RATIO_LOG2:0]    w_unused_sum;

  assign w_diff = $signed({cur_q[15], cur_q}) - $signed({prev_q[15], prev_q});
  assign w_base = $signed({prev_q[15], prev_q, {RATIO_LOG2{1'b0}}});
  assign w_prod = $signed({{RATIO_LOG2{w_diff[16]}}, w_diff}) * $signed({17'd0, k_q});
  assign w_sum  = w_base + w_prod;
  // Taking bits above the fraction is an arithmetic shift, i.e. floor toward -inf.
  assign w_y          = w_sum[RATIO_LOG2 +: 16];
  assign w_unused_sum = {w_sum[c_PW-1], w_sum[RATIO_LOG2-1:0]};
`else
  logic [15:0] w_unused_prev;

  assign w_y           = cur_q;
  assign w_unused_prev = prev_q;
`endif

  always_comb begin
    state_d     = state_q;
    div_d       = w_tick ? '0 : div_q + c_DIV_W'(1);
    k_d         = k_q;
    prev_d      = prev_q;
    cur_d       = cur_q;
    sbuf_d      = sbuf_q;
    sbuf_full_d = sbuf_full_q;
    func_d      = func_q;
    ce_d        = 1'b0;
    underrun_d  = underrun_q;

    if (w_xfer) begin
      sbuf_d      = s_bus.s_data;
      sbuf_full_d = 1'b1;
    end

    case (state_q)
      ST_EMPTY: begin
        if (sbuf_full_q) begin
          prev_d      = sbuf_q;
          cur_d       = sbuf_q;
          sbuf_full_d = 1'b0;
          k_d         = '0;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_tick) begin
          func_d = {~w_y[15], w_y[14:0]};
          ce_d   = 1'b1;
          if (k_q == c_K_LAST) begin
            k_d    = '0;
            prev_d = cur_q;
            if (sbuf_full_q) begin
              cur_d       = sbuf_q;
              sbuf_full_d = 1'b0;
            end else begin
              underrun_d = 1'b1;
            end
          end else begin
            k_d = k_q + RATIO_LOG2'(1);
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_res) begin
    if (!i_res) begin
      state_q     <= ST_EMPTY;
      div_q       <= '0;
      k_q         <= '0;
      prev_q      <= '0;
      cur_q       <= '0;
      sbuf_q      <= '0;
      sbuf_full_q <= 1'b0;
      func_q      <= 16'h8000;
      ce_q        <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      k_q         <= k_d;
      prev_q      <= prev_d;
      cur_q       <= cur_d;
      sbuf_q      <= sbuf_d;
      sbuf_full_q <= sbuf_full_d;
      func_q      <= func_d;
      ce_q        <= ce_d;
      underrun_q  <= underrun_d;
    end
  end

  assign s_bus.s_ready = ~sbuf_full_q;
  assign o_func        = func_q;
  assign o_ce          = ce_q;
  assign o_underrun    = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_interp.sv
`default_nettype none
// tb_dac_interp: directed checks of dac_interp with CLK_DIV=4, RATIO_LOG2=2 (rev 1.0).
module tb_dac_interp;

  logic        clk;
  logic        res_n;
  logic [15:0] o_func;
  logic        o_ce;
  logic        o_underrun;
  int          checks;
  int          errors;
  int          cyc;

  logic [15:0] fq[$];
  int          cq[$];
  logic        uq[$];
  int          xq[$];

  logic [15:0] exp_a [0:9];
  logic [15:0] exp_b [0:7];
  int          exp_x [0:4];

  dac_interp_if bus ();

  dac_interp #(.CLK_DIV(4), .RATIO_LOG2(2)) dut (
    .i_clk      (clk),
    .i_res      (res_n),
    .s_bus      (bus),
    .o_func     (o_func),
    .o_ce       (o_ce),
    .o_underrun (o_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (o_ce === 1'b1) begin
      fq.push_back(o_func);
      cq.push_back(cyc);
      uq.push_back(o_underrun);
    end
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] f_at(input int i);
    return (i < fq.size()) ? fq[i] : 16'hxxxx;
  endfunction

  function automatic logic u_at(input int i);
    return (i < uq.size()) ? uq[i] : 1'bx;
  endfunction

  function automatic int c_at(input int i);
    return (i < cq.size()) ? cq[i] : -1000;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    res_n       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 16'd0;
    repeat (2) @(negedge clk);
    fq.delete();
    cq.delete();
    uq.delete();
    res_n = 1'b1;
  endtask

  task automatic send(input logic [15:0] d);
    int n;
    n = 0;
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    while (bus.s_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(32'(bus.s_ready), 1, "send_ready");
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_strobes(input int n);
    int t;
    t = 0;
    while (fq.size() < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk(32'(fq.size() >= n), 1, "strobe_timeout");
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    res_n       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 16'd0;

`ifdef DAC_INTERP_LINEAR_EN
    exp_a = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
              16'h83E8, 16'h87D0, 16'h8BB8, 16'h8FA0, 16'h8FA0};
    // Ramp 0 -> -3: -3/4, -6/4, -9/4 floor to -1, -2, -3.
    exp_b = '{16'h8000, 16'h8000, 16'h8000, 16'h8000,
              16'h8000, 16'h7FFF, 16'h7FFE, 16'h7FFD};
`else
    exp_a = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8FA0,
              16'h8FA0, 16'h8FA0, 16'h8FA0, 16'h8FA0, 16'h8FA0};
    exp_b = '{16'h8000, 16'h8000, 16'h8000, 16'h8000,
              16'h7FFD, 16'h7FFD, 16'h7FFD, 16'h7FFD};
`endif
    exp_x = '{1, 3, 17, 33, 49};

    // Idle after reset
    do_reset();
    repeat (20) @(negedge clk);
    chk(32'(fq.size()), 0, "idle_no_ce");
    chk(32'(o_func), 32'h8000, "idle_func");
    chk(32'(bus.s_ready), 1, "idle_ready");
    chk(32'(o_underrun), 0, "idle_underrun");

    // Ramp 0 -> 4000 followed by starvation
    send(16'd0);
    chk(32'(bus.s_ready), 0, "ready_after_xfer");
    send(16'd4000);
    wait_strobes(10);
    for (int i = 0; i < 10; i++) begin
      chk(32'(f_at(i)), 32'(exp_a[i]), $sformatf("ramp_func%0d", i));
      chk(32'(u_at(i)), (i >= 7) ? 1 : 0, $sformatf("ramp_underrun%0d", i));
      if (i > 0) chk(32'(c_at(i) - c_at(i - 1)), 4, $sformatf("ramp_gap%0d", i));
    end
    repeat (2) @(negedge clk);
    chk(32'(o_ce), 0, "hold_ce");
    chk(32'(o_func), 32'h8FA0, "hold_func");
    chk(32'(o_underrun), 1, "hold_underrun");

    // Asynchronous reset with a sample still buffered
    send(16'h1234);
    chk(32'(bus.s_ready), 0, "buffered_ready");
    @(posedge clk);
    #3;
    res_n = 1'b0;
    #1;
    chk(32'(o_func), 32'h8000, "async_func");
    chk(32'(o_ce), 0, "async_ce");
    chk(32'(bus.s_ready), 1, "async_ready");
    chk(32'(o_underrun), 0, "async_underrun");

    // Ramp 0 -> -3
    do_reset();
    send(16'd0);
    send(16'hFFFD);
    wait_strobes(8);
    for (int i = 0; i < 8; i++)
      chk(32'(f_at(i)), 32'(exp_b[i]), $sformatf("neg_func%0d", i));

    // Continuous s_valid: transfers at edges 1, 3, then once per group
    do_reset();
    xq.delete();
    bus.s_valid = 1'b1;
    bus.s_data  = 16'd100;
    for (int i = 0; i < 64; i++) begin
      logic rdy;
      rdy = bus.s_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        xq.push_back(i + 1);
        chk(32'(bus.s_ready), 0, $sformatf("stream_ready_fall%0d", i + 1));
      end
      bus.s_data = bus.s_data + 16'd1;
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    chk(32'(xq.size()), 5, "stream_count");
    for (int i = 0; i < 5; i++)
      chk(32'((i < xq.size()) ? xq[i] : -1), 32'(exp_x[i]), $sformatf("stream_edge%0d", i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
